hazard_control: RTL and testbench

HAZARD_CONTROL -- requirements
Module: hazard_control

---
 rtl/hazard_control.sv | 141 ++++++++++++++
 tb/tb_hazard_control.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control.sv
// hazard_control
//   Hazard unit for a five-stage in-order pipeline. It tracks register tags
//   for the EX, MEM and WB stages and uses them to resolve hazards:
//     - Selects forwarding sources for the EX operands.
//     - Detects load-use hazards and stalls for one cycle.
//     - Squashes younger work on a taken branch.
//     - Freezes the whole pipeline while data memory is busy.
//     - Counts stall cycles.
//
// Ports
//   clk, reset                     rising-edge clock, async active-high reset
//   id_rs, id_rt, id_dst           register indices of the instruction in ID
//   id_reg_write, id_mem_read      ID instruction writes the RF / is a load
//   id_valid                       ID holds a real instruction
//   branch_taken                   branch resolved taken in EX
//   mem_busy                       data memory not ready
//   fwd_a, fwd_b                   operand source: 00 RF, 10 EX/MEM, 01 MEM/WB
//   pc_write, ifid_write           PC and IF/ID load enables
//   idex_bubble, ifid_flush        NOP into ID/EX, squash IF/ID
//   freeze                         hold every pipeline register
//   stall_count                    saturating count of stall cycles
module hazard_control #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic [REG_BITS-1:0] id_dst,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_valid,
  input  logic                branch_taken,
  input  logic                mem_busy,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                idex_bubble,
  output logic                ifid_flush,
  output logic                freeze,
  output logic [CNT_BITS-1:0] stall_count
);

  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t              state;
  logic [REG_BITS-1:0] ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic                ex_rw, ex_mr, ex_v, mem_rw, mem_v, wb_rw, wb_v;
  logic                load_use, frozen, br_go, lu_stall;

  localparam logic [REG_BITS-1:0] REG_ZERO = {REG_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

  // Operand source select; EX/MEM beats MEM/WB, and r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_BITS-1:0] src,
    input logic                m_v, m_rw,
    input logic [REG_BITS-1:0] m_dst,
    input logic                w_v, w_rw,
    input logic [REG_BITS-1:0] w_dst
  );
    logic [1:0] sel;
    if (src == REG_ZERO)                         sel = 2'b00;
    else if (m_v && m_rw && (m_dst == src))      sel = 2'b10;
    else if (w_v && w_rw && (w_dst == src))      sel = 2'b01;
    else                                         sel = 2'b00;
    return sel;
  endfunction

  // Hazard detection and pipeline control, mem_busy > branch > load-use.
  always_comb begin
    load_use = ex_v && ex_mr && (ex_dst != REG_ZERO) &&
               ((ex_dst == id_rs) || (ex_dst == id_rt)) && id_valid;
    // MEM_WAIT is left on the first idle cycle, so in both states the
    // freeze follows mem_busy directly; reset overrides everything.
    case (state)
      RUN:      frozen = mem_busy && !reset;
      MEM_WAIT: frozen = mem_busy && !reset;
      default:  frozen = 1'b0;
    endcase
    br_go    = branch_taken && !frozen && !reset;
    lu_stall = load_use && !frozen && !br_go && !reset;

    fwd_a       = fwd_sel(ex_rs, mem_v, mem_rw, mem_dst, wb_v, wb_rw, wb_dst);
    fwd_b       = fwd_sel(ex_rt, mem_v, mem_rw, mem_dst, wb_v, wb_rw, wb_dst);
    freeze      = frozen;
    pc_write    = !(frozen || lu_stall);
    ifid_write  = !(frozen || lu_stall);
    idex_bubble = !frozen && (br_go || lu_stall);
    ifid_flush  = br_go;
  end

  // FSM, stage tags and stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      ex_rs       <= REG_ZERO;
      ex_rt       <= REG_ZERO;
      ex_dst      <= REG_ZERO;
      ex_rw       <= 1'b0;
      ex_mr       <= 1'b0;
      ex_v        <= 1'b0;
      mem_dst     <= REG_ZERO;
      mem_rw      <= 1'b0;
      mem_v       <= 1'b0;
      wb_dst      <= REG_ZERO;
      wb_rw       <= 1'b0;
      wb_v        <= 1'b0;
      stall_count <= {CNT_BITS{1'b0}};
    end else begin
      case (state)
        RUN:      state <= mem_busy ? MEM_WAIT : RUN;
        MEM_WAIT: state <= mem_busy ? MEM_WAIT : RUN;
        default:  state <= RUN;
      endcase

      if ((frozen || lu_stall) && (stall_count != CNT_MAX))
        stall_count <= stall_count + CNT_ONE;

      if (!frozen) begin
        wb_dst  <= mem_dst;
        wb_rw   <= mem_rw;
        wb_v    <= mem_v;
        mem_dst <= ex_dst;
        mem_rw  <= ex_rw;
        mem_v   <= ex_v;
        ex_rs   <= id_rs;
        ex_rt   <= id_rt;
        ex_dst  <= id_dst;
        ex_rw   <= id_reg_write;
        ex_mr   <= id_mem_read;
        // A stalled or branch-squashed ID instruction enters EX as a bubble.
        ex_v    <= id_valid && !(load_use || br_go);
      end
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
module tb_hazard_control;

  localparam int RB = 5;
  localparam int CB = 4;   // narrow counter so saturation is reachable

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [RB-1:0] id_rs = '0, id_rt = '0, id_dst = '0;
  logic          id_reg_write = 1'b0, id_mem_read = 1'b0, id_valid = 1'b0;
  logic          branch_taken = 1'b0, mem_busy = 1'b0;
  logic [1:0]    fwd_a, fwd_b;
  logic          pc_write, ifid_write, idex_bubble, ifid_flush, freeze;
  logic [CB-1:0] stall_count;

  hazard_control #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_valid(id_valid),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .freeze(freeze),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Reference model: instructions in flight, oldest last.
  typedef struct packed {
    logic [RB-1:0] rs, rt, dst;
    logic rw, mr, v;
  } instr_t;

  instr_t in_ex, in_mem, in_wb;
  int     m_cnt;
  logic   e_frz, e_lu, e_stall;
  int     tests = 0;
  int     fails = 0;
  int     c0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which older instruction supplies register r: the youngest writer wins.
  function automatic logic [1:0] supplier(input logic [RB-1:0] r);
    instr_t older[2];
    logic [1:0] code[2];
    older[0] = in_mem; code[0] = 2'b10;
    older[1] = in_wb;  code[1] = 2'b01;
    if (r == 0) return 2'b00;
    for (int k = 0; k < 2; k++)
      if (older[k].v && older[k].rw && older[k].dst == r) return code[k];
    return 2'b00;
  endfunction

  task automatic model_clear();
    in_ex = '0; in_mem = '0; in_wb = '0; m_cnt = 0;
  endtask

  // Apply inputs for one cycle and check every output against the model.
  task automatic drive(input logic [RB-1:0] rs, rt, dst,
                       input logic rw, mr, v, br, busy);
    logic br_e;
    id_rs = rs; id_rt = rt; id_dst = dst;
    id_reg_write = rw; id_mem_read = mr; id_valid = v;
    branch_taken = br; mem_busy = busy;
    #1;
    e_frz   = busy;
    br_e    = br && !e_frz;
    e_lu    = in_ex.v && in_ex.mr && in_ex.dst != 0 &&
              (in_ex.dst == rs || in_ex.dst == rt) && v;
    e_stall = e_lu && !e_frz && !br_e;
    chk("fwd_a", 32'(fwd_a), 32'(supplier(in_ex.rs)));
    chk("fwd_b", 32'(fwd_b), 32'(supplier(in_ex.rt)));
    chk("freeze", 32'(freeze), 32'(e_frz));
    chk("pc_write", 32'(pc_write), 32'(!(e_frz || e_stall)));
    chk("ifid_write", 32'(ifid_write), 32'(!(e_frz || e_stall)));
    chk("idex_bubble", 32'(idex_bubble), 32'(!e_frz && (br_e || e_stall)));
    chk("ifid_flush", 32'(ifid_flush), 32'(br_e));
    chk("stall_count", 32'(stall_count), 32'(m_cnt));
  endtask

  task automatic tick();
    instr_t nx;
    nx = '{rs: id_rs, rt: id_rt, dst: id_dst, rw: id_reg_write, mr: id_mem_read,
           v: id_valid && !(e_lu || branch_taken)};
    @(posedge clk);
    if ((e_frz || e_stall) && m_cnt < (1 << CB) - 1) m_cnt++;
    if (!e_frz) begin
      in_wb = in_mem; in_mem = in_ex; in_ex = nx;
    end
    #1;
  endtask

  task automatic idle(input logic br, busy);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, br, busy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_clear();
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_count", 32'(stall_count), 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    chk("rst_ifid_write", 32'(ifid_write), 32'd1);
    chk("rst_bubble", 32'(idex_bubble), 32'd0);
    chk("rst_flush", 32'(ifid_flush), 32'd0);
    chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic br_hold;
    #2;
    do_reset();

    // Load-use: lw r4 then add r4.
    drive(5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd4, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lu_pc_write", 32'(pc_write), 32'd0);
    chk("lu_bubble", 32'(idex_bubble), 32'd1);
    tick();
    drive(5'd4, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lu_count", 32'(stall_count), 32'd1);
    chk("lu_released", 32'(pc_write), 32'd1);
    tick();
    idle(1'b0, 1'b0);
    chk("lu_fwd_a", 32'(fwd_a), 32'b01);
    tick();

    // ALU chain on r3.
    drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd3, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("chain_ex_mem", 32'(fwd_a), 32'b10);
    tick();
    idle(1'b0, 1'b0);
    chk("chain_mem_wb", 32'(fwd_a), 32'b01);
    tick();

    // Double hit on r5: EX/MEM wins.
    drive(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd1, 5'd5, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    idle(1'b0, 1'b0);
    chk("double_hit_b", 32'(fwd_b), 32'b10);
    tick();

    // r0 is never forwarded.
    drive(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    idle(1'b0, 1'b0);
    chk("r0_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    tick();

    // mem_busy for 3 cycles with a branch held asserted.
    drive(5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(5'd9, 5'd3, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("busy_freeze", 32'(freeze), 32'd1);
      chk("busy_no_flush", 32'(ifid_flush), 32'd0);
      chk("busy_held_fwd", 32'(fwd_a), 32'b10);
      tick();
    end
    drive(5'd9, 5'd3, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("busy_count", 32'(stall_count), 32'(c0 + 3));
    chk("release_flush", 32'(ifid_flush), 32'd1);
    chk("release_freeze", 32'(freeze), 32'd0);
    tick();

    // Reset while in MEM_WAIT with forwarding tags in flight.
    drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    idle(1'b0, 1'b1); tick();
    idle(1'b0, 1'b1); tick();
    do_reset();
    drive(5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_nofwd", 32'({fwd_a, fwd_b}), 32'd0);
    tick();

    // Randomised traffic; a taken branch stays up while the pipe is frozen.
    br_hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic br, busy;
      busy = ($urandom_range(0, 5) == 0);
      br   = br_hold ? 1'b1 : ($urandom_range(0, 6) == 0);
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 4) != 0), br, busy);
      br_hold = br && busy;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
